// File: rtl/cmul_rr_sched_pkg.sv
// ============================================================================
// Module     : cmul_rr_sched_pkg
// Description: Fixed-point defaults and complex-operand type shared by all
//              clients of the mult_add datapath.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmul_rr_sched_pkg;

  localparam int c_data_width = 20;
  localparam int c_frac       = 16;

  typedef struct packed {
    logic [c_data_width-1:0] re;
    logic [c_data_width-1:0] im;
  } cplx_t;

endpackage

`default_nettype wire

// File: rtl/cmul_rr_arb.sv
// ============================================================================
// Module     : cmul_rr_arb
// Description: Round-robin one-hot grant with rotating priority pointer.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmul_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id
);

  logic [ID_W-1:0] r_ptr;
  logic            w_found;
  int              w_idx;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(r_ptr) + i) % NUM_REQ;
      if (!w_found && i_en && i_req_valid[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grant_id     = ID_W'(w_idx);
        w_found        = 1'b1;
      end
    end
  end

  // Priority restarts just past the most recently served requester.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (o_grant_id == ID_W'(NUM_REQ-1)) ? '0 : o_grant_id + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_add.sv
// ============================================================================
// Module     : mult_add
// Description: Two signed fixed-point products, sliced [FRAC +: DATA_WIDTH],
//              summed (ADD=1) or one's-complement subtracted (ADD=0).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_add #(
  parameter int DATA_WIDTH = 20,
  parameter int FRAC       = 16,
  parameter int ADD        = 0
) (
  input  logic [DATA_WIDTH-1:0] i_a0,
  input  logic [DATA_WIDTH-1:0] i_b0,
  input  logic [DATA_WIDTH-1:0] i_a1,
  input  logic [DATA_WIDTH-1:0] i_b1,
  output logic [DATA_WIDTH-1:0] o_y
);

  logic signed [2*DATA_WIDTH-1:0] w_p0;
  logic signed [2*DATA_WIDTH-1:0] w_p1;
  logic [DATA_WIDTH-1:0]          w_s0;
  logic [DATA_WIDTH-1:0]          w_s1;
  logic                           w_unused_bits;

  assign w_p0 = $signed(i_a0) * $signed(i_b0);
  assign w_p1 = $signed(i_a1) * $signed(i_b1);
  assign w_s0 = w_p0[FRAC +: DATA_WIDTH];
  assign w_s1 = w_p1[FRAC +: DATA_WIDTH];

  // Truncated product bits are discarded by design (no rounding/saturation).
  assign w_unused_bits = ^{w_p0[FRAC-1:0], w_p0[2*DATA_WIDTH-1:FRAC+DATA_WIDTH],
                           w_p1[FRAC-1:0], w_p1[2*DATA_WIDTH-1:FRAC+DATA_WIDTH]};

  generate
    if (ADD != 0) begin : g_add
      assign o_y = w_s0 + w_s1;
    end else begin : g_sub
      assign o_y = w_s0 + ~w_s1;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cmul_rr_sched.sv
// ============================================================================
// Module     : cmul_rr_sched
// Description: Round-robin scheduler sharing one complex multiplier among
//              NUM_REQ requesters through a 2-stage stallable pipeline.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmul_rr_sched
  import cmul_rr_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = c_data_width,
  parameter int FRAC       = c_frac,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_ar,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_ai,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_br,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_bi,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_re,
  output logic [DATA_WIDTH-1:0]         o_im,
  output logic [ID_W-1:0]               o_id,
  output logic                          o_busy
);

  // The shared operand struct is sized by the package width.
  generate
    if (DATA_WIDTH != c_data_width) begin : g_dw_check
      $error("cmul_rr_sched: DATA_WIDTH must equal the package operand width");
    end
  endgenerate

  logic                  r_s1_valid;
  cplx_t                 r_s1_a;
  cplx_t                 r_s1_b;
  logic [ID_W-1:0]       r_s1_id;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_re;
  logic [DATA_WIDTH-1:0] r_im;
  logic [ID_W-1:0]       r_id;

  logic                  w_adv1;
  logic                  w_adv2;
  logic                  w_fire;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_gid;
  cplx_t                 w_sel_a;
  cplx_t                 w_sel_b;
  logic [DATA_WIDTH-1:0] w_re;
  logic [DATA_WIDTH-1:0] w_im;

  assign w_adv2 = !r_out_valid || i_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;
  assign w_fire = |w_grant;

  cmul_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (w_adv1 && i_rst_n),
    .i_req_valid (i_req_valid),
    .o_grant     (w_grant),
    .o_grant_id  (w_gid)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_a.re = i_ar[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_a.im = i_ai[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_b.re = i_br[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_b.im = i_bi[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  mult_add #(.DATA_WIDTH(DATA_WIDTH), .FRAC(FRAC), .ADD(0)) u_mul_re (
    .i_a0 (r_s1_a.re),
    .i_b0 (r_s1_b.re),
    .i_a1 (r_s1_a.im),
    .i_b1 (r_s1_b.im),
    .o_y  (w_re)
  );

  mult_add #(.DATA_WIDTH(DATA_WIDTH), .FRAC(FRAC), .ADD(1)) u_mul_im (
    .i_a0 (r_s1_a.re),
    .i_b0 (r_s1_b.im),
    .i_a1 (r_s1_a.im),
    .i_b1 (r_s1_b.re),
    .o_y  (w_im)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_id     <= '0;
      r_out_valid <= 1'b0;
      r_re        <= '0;
      r_im        <= '0;
      r_id        <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= w_fire;
        if (w_fire) begin
          r_s1_a  <= w_sel_a;
          r_s1_b  <= w_sel_b;
          r_s1_id <= w_gid;
        end
      end
      // Output registers only move on drain, keeping o_* stable under stall.
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_re <= w_re;
          r_im <= w_im;
          r_id <= r_s1_id;
        end
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_valid     = r_out_valid;
  assign o_re        = r_re;
  assign o_im        = r_im;
  assign o_id        = r_id;
  assign o_busy      = r_s1_valid || r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_cmul_rr_sched.sv
// ============================================================================
// Module     : tb_cmul_rr_sched
// Description: Self-checking bench for cmul_rr_sched against a queue model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmul_rr_sched;

  localparam int N    = 4;
  localparam int DW   = 20;
  localparam int FRAC = 16;
  localparam int IDW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] ar [N];
  logic [DW-1:0] ai [N];
  logic [DW-1:0] br [N];
  logic [DW-1:0] bi [N];
  logic [N*DW-1:0] ar_bus, ai_bus, br_bus, bi_bus;
  logic          dut_valid;
  logic          ready;
  logic [DW-1:0] re, im;
  logic [IDW-1:0] id;
  logic          busy;

  always #5 clk = ~clk;

  always_comb begin
    ar_bus = '0; ai_bus = '0; br_bus = '0; bi_bus = '0;
    for (int k = 0; k < N; k++) begin
      ar_bus[k*DW +: DW] = ar[k];
      ai_bus[k*DW +: DW] = ai[k];
      br_bus[k*DW +: DW] = br[k];
      bi_bus[k*DW +: DW] = bi[k];
    end
  end

  cmul_rr_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .FRAC(FRAC), .ID_W(IDW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_ar        (ar_bus),
    .i_ai        (ai_bus),
    .i_br        (br_bus),
    .i_bi        (bi_bus),
    .o_valid     (dut_valid),
    .i_ready     (ready),
    .o_re        (re),
    .o_im        (im),
    .o_id        (id),
    .o_busy      (busy)
  );

  // Reference model: FIFO of accepted items; age = clock edges since accept.
  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    int            id;
    int            age;
  } item_t;

  item_t m_q[$];
  int    m_ptr;
  int    n_pass, n_total;
  int    n_acc;

  function automatic logic [DW-1:0] prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint p;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> FRAC;
    return p[DW-1:0];
  endfunction

  function automatic bit can_accept();
    return rst_n && ((m_q.size() < 2) || ready);
  endfunction

  function automatic bit exp_valid();
    return (m_q.size() > 0) && (m_q[0].age >= 2);
  endfunction

  function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v);
    logic [N-1:0] g;
    g = '0;
    if (can_accept()) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (v[k] && g == '0) g[k] = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [2*DW+IDW-1:0] head_word();
    return {m_q[0].re, m_q[0].im, IDW'(m_q[0].id)};
  endfunction

  // Advance one clock and update the model; no comparisons here.
  task automatic step();
    logic [N-1:0] g;
    bit           pop;
    item_t        it;
    g   = exp_grant(req_valid);
    pop = exp_valid() && ready;
    @(posedge clk);
    if (rst_n) begin
      if (pop) void'(m_q.pop_front());
      foreach (m_q[j]) m_q[j].age = m_q[j].age + 1;
      for (int k = 0; k < N; k++) begin
        if (g[k]) begin
          it.re  = prod(ar[k], br[k]) - prod(ai[k], bi[k]) - 1'b1;
          it.im  = prod(ar[k], bi[k]) + prod(ai[k], br[k]);
          it.id  = k;
          it.age = 1;
          m_q.push_back(it);
          m_ptr = (k == N-1) ? 0 : k + 1;
          n_acc++;
        end
      end
    end
    #1;
  endtask

  task automatic randomize_operands();
    for (int k = 0; k < N; k++) begin
      ar[k] = DW'($urandom); ai[k] = DW'($urandom);
      br[k] = DW'($urandom); bi[k] = DW'($urandom);
    end
  endtask

  task automatic reset_dut();
    req_valid = '0;
    rst_n     = 1'b0;
    m_q.delete();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    ready     = 1'b1;
    rst_n     = 1'b0;
    randomize_operands();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({dut_valid, re, im, id, busy} !== '0) $display("FAIL reset_outputs: got v=%b re=%h im=%h id=%0d busy=%b want all zero", dut_valid, re, im, id, busy);
    else n_pass++;
    n_total++;
    if (req_ready !== '0) $display("FAIL reset_ready: got %b want 0000", req_ready);
    else n_pass++;
    req_valid = '0;
    m_q.delete();
    m_ptr = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [DW-1:0] w_re [2] = '{20'hFFFFF, 20'h0FFFF};
    logic [DW-1:0] w_im [2] = '{20'h20000, 20'h00000};
    int            w_id [2] = '{0, 2};
    reset_dut();
    ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      randomize_operands();
      if (t == 0) begin
        ar[0] = 20'h10000; ai[0] = 20'h10000; br[0] = 20'h10000; bi[0] = 20'h10000;
      end else begin
        ar[2] = 20'h08000; ai[2] = '0; br[2] = 20'h20000; bi[2] = '0;
      end
      req_valid = N'(1) << w_id[t];
      @(negedge clk);
      n_total++;
      if (req_ready !== (N'(1) << w_id[t])) $display("FAIL dir%0d_grant: got %b want %b", t, req_ready, N'(1) << w_id[t]);
      else n_pass++;
      step();
      req_valid = '0;
      @(negedge clk);
      n_total++;
      if (dut_valid !== 1'b0 || busy !== 1'b1) $display("FAIL dir%0d_latency: got v=%b busy=%b want v=0 busy=1", t, dut_valid, busy);
      else n_pass++;
      step();
      @(negedge clk);
      n_total++;
      if ({dut_valid, re, im, id} !== {1'b1, w_re[t], w_im[t], IDW'(w_id[t])})
        $display("FAIL dir%0d_result: got v=%b re=%h im=%h id=%0d want v=1 re=%h im=%h id=%0d", t, dut_valid, re, im, id, w_re[t], w_im[t], w_id[t]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_all_valid();
    reset_dut();
    ready     = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      randomize_operands();
      @(negedge clk);
      n_total++;
      if (req_ready !== (N'(1) << (c % N))) $display("FAIL allv_grant c%0d: got %b want %b", c, req_ready, N'(1) << (c % N));
      else n_pass++;
      if (c >= 2) begin
        n_total++;
        if (dut_valid !== 1'b1 || id !== IDW'((c - 2) % N)) $display("FAIL allv_out c%0d: got v=%b id=%0d want v=1 id=%0d", c, dut_valid, id, (c - 2) % N);
        else n_pass++;
        n_total++;
        if (m_q.size() == 0 || {re, im, id} !== head_word()) $display("FAIL allv_data c%0d: got re=%h im=%h want model head", c, re, im);
        else n_pass++;
      end
      step();
    end
    req_valid = '0;
    repeat (3) step();
  endtask

  task automatic test_stall();
    logic [2*DW+IDW-1:0] held;
    int                  n_obs;
    reset_dut();
    n_acc = 0;
    n_obs = 0;
    ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      randomize_operands();
      @(negedge clk);
      if (dut_valid && ready) n_obs++;
      step();
    end
    ready = 1'b0;
    @(negedge clk);
    held = {re, im, id};
    for (int c = 0; c < 5; c++) begin
      randomize_operands();
      @(negedge clk);
      n_total++;
      if (req_ready !== '0 || dut_valid !== 1'b1 || {re, im, id} !== held)
        $display("FAIL stall_hold c%0d: got rdy=%b v=%b word=%h want rdy=0 v=1 word=%h", c, req_ready, dut_valid, {re, im, id}, held);
      else n_pass++;
      step();
    end
    ready = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++;
      if (dut_valid !== exp_valid() || (exp_valid() && {re, im, id} !== head_word()))
        $display("FAIL stall_drain c%0d: got v=%b word=%h want v=%b", c, dut_valid, {re, im, id}, exp_valid());
      else n_pass++;
      if (dut_valid && ready) n_obs++;
      step();
    end
    n_total++;
    if (n_obs !== n_acc || busy !== 1'b0) $display("FAIL stall_count: got out=%0d busy=%b want out=%0d busy=0", n_obs, busy, n_acc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [N-1:0] v_in [3]  = '{4'b0010, 4'b0001, 4'b0011};
    logic [N-1:0] g_exp [3] = '{4'b0010, 4'b0001, 4'b0010};
    reset_dut();
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randomize_operands();
      req_valid = v_in[c];
      @(negedge clk);
      n_total++;
      if (req_ready !== g_exp[c]) $display("FAIL wrap_grant c%0d: got %b want %b", c, req_ready, g_exp[c]);
      else n_pass++;
      step();
    end
    req_valid = '0;
    repeat (3) step();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      randomize_operands();
      req_valid = N'($urandom);
      ready     = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      n_total++;
      if (req_ready !== exp_grant(req_valid)) $display("FAIL rnd_grant c%0d: got %b want %b", c, req_ready, exp_grant(req_valid));
      else n_pass++;
      n_total++;
      if (dut_valid !== exp_valid() || busy !== (m_q.size() > 0)) $display("FAIL rnd_valid c%0d: got v=%b busy=%b want v=%b busy=%b", c, dut_valid, busy, exp_valid(), m_q.size() > 0);
      else n_pass++;
      if (exp_valid()) begin
        n_total++;
        if ({re, im, id} !== head_word()) $display("FAIL rnd_data c%0d: got %h want %h", c, {re, im, id}, head_word());
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_midreset();
    reset_dut();
    ready = 1'b1;
    randomize_operands();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0110;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (dut_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) $display("FAIL midrst_clear: got v=%b busy=%b rdy=%b want 0 0 0000", dut_valid, busy, req_ready);
    else n_pass++;
    m_q.delete();
    m_ptr = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 4'b0010) $display("FAIL midrst_grant: got %b want 0010", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    repeat (3) step();
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_acc = 0; m_ptr = 0;
    rst_n = 1'b0; ready = 1'b1; req_valid = '0;
    randomize_operands();
    test_reset();
    test_directed();
    test_all_valid();
    test_stall();
    test_wrap();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
